// File: rtl/xfer_arbiter.sv
// Round-robin arbiter for the shared scanner transfer link: arm a requester,
// grant on a start edge, count BUF_DEPTH ticks, then pulse done and hold off.
module xfer_arbiter #(
    parameter int BUF_DEPTH = 10,
    parameter int CNT_W     = 4,
    parameter int HOLDOFF   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       req,
    input  logic             start_transfer,
    output logic [1:0]       armed,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] xfer_prog,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    localparam int                HOLD_N    = (HOLDOFF < 1) ? 1 : HOLDOFF;
    localparam int                HOLD_W    = $clog2(HOLD_N + 1);
    localparam logic [CNT_W-1:0]  PROG_END  = CNT_W'(BUF_DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);

    typedef enum logic [1:0] {IDLE, ARM, XFER, DONE} state_t;

    state_t             state;
    logic               sel;
    logic               last_served;
    logic               start_q;
    logic               start_edge;
    logic               pick;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]   prog_inc;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    assign start_edge = start_transfer & ~start_q;
    assign prog_inc   = xfer_prog + CNT_W'(1);

    // A lone requester wins outright; a tie goes to whoever was not served last.
    always_comb begin
        pick = ~last_served;
        if (req == 2'b01)
            pick = 1'b0;
        else if (req == 2'b10)
            pick = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            last_served <= 1'b1;
            start_q     <= 1'b0;
            hold_cnt    <= '0;
            armed       <= 2'b00;
            grant       <= 2'b00;
            xfer_prog   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            start_q <= start_transfer;
            done    <= 1'b0;
            abort   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= pick;
                        armed <= onehot(pick);
                        busy  <= 1'b1;
                        state <= ARM;
                    end
                end
                ARM: begin
                    // Owner withdrawal outranks a simultaneous start edge.
                    if (!req[sel]) begin
                        armed <= 2'b00;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                        state <= IDLE;
                    end else if (start_edge) begin
                        armed     <= 2'b00;
                        grant     <= onehot(sel);
                        xfer_prog <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (!req[sel]) begin
                        grant     <= 2'b00;
                        xfer_prog <= '0;
                        busy      <= 1'b0;
                        abort     <= 1'b1;
                        state     <= IDLE;
                    end else if (tick && xfer_prog != PROG_END) begin
                        xfer_prog <= prog_inc;
                        if (prog_inc == PROG_END) begin
                            grant       <= 2'b00;
                            done        <= 1'b1;
                            last_served <= sel;
                            hold_cnt    <= '0;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        xfer_prog <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xfer_arbiter.sv
// Bench for xfer_arbiter: event-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_xfer_arbiter;

    localparam int BUF_DEPTH = 10;
    localparam int CNT_W     = 4;
    localparam int HOLDOFF   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [1:0]       req;
    logic             start_transfer;
    logic [1:0]       armed;
    logic [1:0]       grant;
    logic [CNT_W-1:0] xfer_prog;
    logic             busy;
    logic             done;
    logic             abort;

    int n_cmp  = 0;
    int n_fail = 0;

    xfer_arbiter #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req),
        .start_transfer(start_transfer), .armed(armed), .grant(grant),
        .xfer_prog(xfer_prog), .busy(busy), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: who owns the link, whether it is granted, how far along,
    // and how many hold-off cycles remain after a completion.
    int m_owner   = -1;
    int m_granted = 0;
    int m_count   = 0;
    int m_hold    = 0;
    int m_last    = 1;
    int m_done    = 0;
    int m_abort   = 0;
    bit m_sp      = 1'b0;
    bit m_valid   = 1'b0;

    always @(posedge clk) begin : model
        bit edge_seen;
        if (reset) begin
            m_owner = -1; m_granted = 0; m_count = 0; m_hold = 0;
            m_last = 1; m_done = 0; m_abort = 0; m_sp = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            edge_seen = start_transfer && !m_sp;
            m_sp      = start_transfer;
            m_done    = 0;
            m_abort   = 0;
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_count = 0;
            end else if (m_owner < 0) begin
                if (req == 2'b01)      m_owner = 0;
                else if (req == 2'b10) m_owner = 1;
                else if (req == 2'b11) m_owner = 1 - m_last;
            end else if (!req[m_owner]) begin
                m_owner = -1; m_granted = 0; m_count = 0; m_abort = 1;
            end else if (!m_granted) begin
                if (edge_seen) begin
                    m_granted = 1; m_count = 0;
                end
            end else if (tick) begin
                m_count++;
                if (m_count == BUF_DEPTH) begin
                    m_last = m_owner; m_owner = -1; m_granted = 0;
                    m_done = 1; m_hold = HOLDOFF;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int e_armed, e_grant, e_busy;
        if (m_valid) begin
            e_armed = (m_owner >= 0 && !m_granted) ? (1 << m_owner) : 0;
            e_grant = (m_owner >= 0 && m_granted) ? (1 << m_owner) : 0;
            e_busy  = (m_owner >= 0 || m_hold > 0) ? 1 : 0;
            chk("m_armed", armed, e_armed);
            chk("m_grant", grant, e_grant);
            chk("m_prog", xfer_prog, m_count);
            chk("m_busy", busy, e_busy);
            chk("m_done", done, m_done);
            chk("m_abort", abort, m_abort);
            chk("inv_arm_grant", (|armed) && (|grant), 0);
            chk("inv_onehot", $onehot0(armed) && $onehot0(grant), 1);
            chk("inv_done_abort", done && abort, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sel;
        reset = 1'b1; tick = 1'b0; req = 2'b00; start_transfer = 1'b0;
        cyc(2);
        chk("rst_armed", armed, 0);
        chk("rst_grant", grant, 0);
        chk("rst_prog", xfer_prog, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);

        // Single requester, full transfer
        reset = 1'b0; req = 2'b01;
        cyc(1);
        chk("s1_armed", armed, 1);
        chk("s1_busy", busy, 1);
        start_transfer = 1'b1;
        cyc(1);
        chk("s1_grant", grant, 1);
        chk("s1_armed_clr", armed, 0);
        start_transfer = 1'b0;
        for (int k = 1; k <= BUF_DEPTH; k++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            chk("s1_prog", xfer_prog, k);
            if (k < BUF_DEPTH) begin
                chk("s1_grant_hold", grant, 1);
            end else begin
                chk("s1_grant_end", grant, 0);
                chk("s1_done", done, 1);
            end
        end
        req = 2'b00;
        cyc(1);
        chk("s1_done_pulse", done, 0);
        chk("s1_busy_hold", busy, 1);
        chk("s1_prog_hold", xfer_prog, 10);
        cyc(1);
        chk("s1_busy_idle", busy, 0);
        chk("s1_prog_idle", xfer_prog, 0);

        // Both requesting: strict alternation from scan1
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; req = 2'b11;
        cyc(1);
        for (int t = 0; t < 4; t++) begin
            exp_sel = (t % 2 == 0) ? 1 : 2;
            chk("s2_armed", armed, exp_sel);
            start_transfer = 1'b1;
            cyc(1);
            start_transfer = 1'b0;
            chk("s2_grant", grant, exp_sel);
            tick = 1'b1;
            cyc(BUF_DEPTH);
            tick = 1'b0;
            chk("s2_done", done, 1);
            chk("s2_prog", xfer_prog, 10);
            cyc(HOLDOFF);
            chk("s2_idle", busy, 0);
            cyc(1);
        end

        // Owner drops in ARM together with a start edge
        chk("s3_armed", armed, 1);
        req = 2'b10; start_transfer = 1'b1;
        cyc(1);
        chk("s3_abort", abort, 1);
        chk("s3_grant", grant, 0);
        chk("s3_busy", busy, 0);
        start_transfer = 1'b0; req = 2'b00;
        cyc(1);
        chk("s3_abort_pulse", abort, 0);
        chk("s3_grant_never", grant, 0);
        req = 2'b11;
        cyc(1);
        chk("s3_last_kept", armed, 1);

        // Owner drops mid-transfer
        start_transfer = 1'b1;
        cyc(1);
        start_transfer = 1'b0;
        chk("s4_grant", grant, 1);
        tick = 1'b1;
        cyc(5);
        tick = 1'b0;
        chk("s4_prog", xfer_prog, 5);
        req = 2'b10;
        cyc(1);
        chk("s4_abort", abort, 1);
        chk("s4_grant", grant, 0);
        chk("s4_prog0", xfer_prog, 0);
        chk("s4_busy", busy, 0);
        req = 2'b00;
        cyc(1);

        // Reset with tick mid-transfer
        req = 2'b01;
        cyc(1);
        start_transfer = 1'b1;
        cyc(1);
        start_transfer = 1'b0;
        tick = 1'b1;
        cyc(7);
        tick = 1'b0;
        chk("s5_prog", xfer_prog, 7);
        reset = 1'b1; tick = 1'b1;
        cyc(1);
        chk("s5_prog", xfer_prog, 0);
        chk("s5_grant", grant, 0);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        reset = 1'b0; tick = 1'b0; req = 2'b00;
        cyc(1);

        // Start held high across IDLE->ARM is ignored until re-pressed
        start_transfer = 1'b1; req = 2'b01;
        cyc(1);
        chk("s6_armed", armed, 1);
        cyc(3);
        chk("s6_no_grant", grant, 0);
        chk("s6_still_armed", armed, 1);
        start_transfer = 1'b0;
        cyc(1);
        start_transfer = 1'b1;
        cyc(1);
        chk("s6_grant", grant, 1);
        start_transfer = 1'b0; req = 2'b00;
        cyc(1);
        chk("s6_abort", abort, 1);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
